// File: rtl/audio_if_pkg.sv
// Shared constants and types for the host-to-synth audio write path.
// Register map and sample placement match the sample read-out mux.
package audio_if_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_pair_t;

    localparam logic [1:0] ADDR_LEFT   = 2'd0;
    localparam logic [1:0] ADDR_RIGHT  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_FLUSH = 2;

    localparam int STAT_EN       = 0;
    localparam int STAT_UNDERRUN = 1;
    localparam int STAT_OVERFLOW = 2;

    // Samples sit left-justified in the 32-bit bus word.
    function automatic logic [31:0] sample_to_word(input sample_t s);
        return {s, 8'h00};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous stereo-pair FIFO with a registered read port.
// Flush wins over push and pop; a push into a full FIFO is accepted only alongside a pop.
module sample_fifo
    import audio_if_pkg::*;
#(
    parameter int FIFO_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [2*SAMPLE_W-1:0] din,
    output logic [2*SAMPLE_W-1:0] dout,
    output logic [FIFO_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] FULL_LEVEL = {1'b1, {FIFO_WIDTH{1'b0}}};

    logic [2*SAMPLE_W-1:0] mem [DEPTH];
    logic [FIFO_WIDTH-1:0] wr_ptr;
    logic [FIFO_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_in_demux.sv
// Avalon-MM slave that queues host-written stereo pairs and releases one
// pair per LRCK frame toward the DAC/mixer path.
module audio_in_demux
    import audio_if_pkg::*;
#(
    parameter int FIFO_WIDTH = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         datain,
    output logic [31:0]         dataout,
    input  logic                lrck,
    output logic [SAMPLE_W-1:0] lsound_out,
    output logic [SAMPLE_W-1:0] rsound_out,
    output logic                sample_valid,
    output logic [FIFO_WIDTH:0] fifo_level,
    output logic                refill_req,
    output logic                underrun,
    output logic                overflow
);

    // Bus protocol: read and write are single-cycle strobes with no wait states;
    // write effects land on the strobe's edge, dataout is valid the cycle after read.

    sample_t               left_hold;
    logic                  enable;
    logic [FIFO_WIDTH:0]   threshold;
    logic                  lrck_s1, lrck_s2, lrck_d;
    logic                  tick_d, pop_d;
    logic                  frame_tick;
    logic                  wr_left, wr_right, wr_ctrl, wr_thresh;
    logic                  clr_flags, flush;
    logic                  fifo_full, fifo_empty;
    logic                  push_ok, pop_ok;
    logic                  overflow_evt, underrun_evt;
    logic [2*SAMPLE_W-1:0] fifo_dout;
    stereo_pair_t          out_pair;
    logic                  en_nxt;
    logic [FIFO_WIDTH:0]   thr_nxt, lvl_nxt;
    logic                  unused_datain;

    assign wr_left   = write && (address == ADDR_LEFT);
    assign wr_right  = write && (address == ADDR_RIGHT);
    assign wr_ctrl   = write && (address == ADDR_CTRL);
    assign wr_thresh = write && (address == ADDR_THRESH);
    assign clr_flags = wr_ctrl && datain[CTRL_CLR];
    assign flush     = wr_ctrl && datain[CTRL_FLUSH];

    assign frame_tick   = lrck_s2 && !lrck_d;
    assign pop_ok       = frame_tick && enable && !fifo_empty && !flush;
    assign push_ok      = wr_right && !flush && (!fifo_full || pop_ok);
    assign overflow_evt = wr_right && !flush && fifo_full && !pop_ok;
    assign underrun_evt = frame_tick && enable && fifo_empty;
    assign out_pair     = stereo_pair_t'(fifo_dout);
    assign unused_datain = ^datain;

    sample_fifo #(.FIFO_WIDTH(FIFO_WIDTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (pop_ok),
        .flush   (flush),
        .din     ({left_hold, datain[31:32-SAMPLE_W]}),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // refill_req is computed from next-state values so it moves on the same edge as the level.
    always_comb begin
        en_nxt  = enable;
        thr_nxt = threshold;
        lvl_nxt = fifo_level;
        if (wr_ctrl) begin
            en_nxt = datain[CTRL_EN];
        end
        if (wr_thresh) begin
            thr_nxt = datain[FIFO_WIDTH:0];
        end
        if (flush) begin
            lvl_nxt = '0;
        end else begin
            lvl_nxt = fifo_level + (FIFO_WIDTH+1)'(push_ok) - (FIFO_WIDTH+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_s1      <= 1'b0;
            lrck_s2      <= 1'b0;
            lrck_d       <= 1'b0;
            left_hold    <= '0;
            enable       <= 1'b0;
            threshold    <= '0;
            tick_d       <= 1'b0;
            pop_d        <= 1'b0;
            sample_valid <= 1'b0;
            lsound_out   <= '0;
            rsound_out   <= '0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
            refill_req   <= 1'b0;
            dataout      <= '0;
        end else begin
            lrck_s1 <= lrck;
            lrck_s2 <= lrck_s1;
            lrck_d  <= lrck_s2;

            if (wr_left)   left_hold <= datain[31:32-SAMPLE_W];
            if (wr_ctrl)   enable    <= datain[CTRL_EN];
            if (wr_thresh) threshold <= datain[FIFO_WIDTH:0];

            // A frame without a popped pair (disabled, empty or flushed) outputs silence.
            tick_d       <= frame_tick;
            pop_d        <= pop_ok;
            sample_valid <= tick_d;
            if (tick_d) begin
                lsound_out <= pop_d ? out_pair.left  : '0;
                rsound_out <= pop_d ? out_pair.right : '0;
            end

            if (overflow_evt)   overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (underrun_evt)   underrun <= 1'b1;
            else if (clr_flags) underrun <= 1'b0;

            refill_req <= en_nxt && (lvl_nxt < thr_nxt);

            if (read) begin
                case (address)
                    ADDR_LEFT:  dataout <= sample_to_word(left_hold);
                    ADDR_RIGHT: dataout <= sample_to_word(rsound_out);
                    ADDR_CTRL: begin
                        dataout                <= '0;
                        dataout[STAT_EN]       <= enable;
                        dataout[STAT_UNDERRUN] <= underrun;
                        dataout[STAT_OVERFLOW] <= overflow;
                    end
                    default:    dataout <= 32'(fifo_level);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_in_demux.sv
// Directed bench for audio_in_demux: register table, overflow/drain, underrun,
// refill threshold, flush against a frame, and asynchronous reset.
module tb_audio_in_demux;
    import audio_if_pkg::*;

    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   datain = '0;
    logic [31:0]   dataout;
    logic          lrck = 1'b0;
    logic [23:0]   lsound_out, rsound_out;
    logic          sample_valid;
    logic [FW:0]   fifo_level;
    logic          refill_req, underrun, overflow;

    int checks = 0;
    int failures = 0;
    logic [47:0] exp_q[$];

    audio_in_demux #(.FIFO_WIDTH(FW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .read         (read),
        .write        (write),
        .datain       (datain),
        .dataout      (dataout),
        .lrck         (lrck),
        .lsound_out   (lsound_out),
        .rsound_out   (rsound_out),
        .sample_valid (sample_valid),
        .fifo_level   (fifo_level),
        .refill_req   (refill_req),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address = a;
        datain  = d;
        write   = 1'b1;
        step(1);
        write   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        step(1);
        read    = 1'b0;
        d       = dataout;
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        write_reg(ADDR_LEFT, {l, 8'h00});
        write_reg(ADDR_RIGHT, {r, 8'h00});
    endtask

    // Raise lrck, land just after the output edge, check, then hold lrck low.
    task automatic frame_check(input logic [23:0] el, input logic [23:0] er, input string name);
        lrck = 1'b1;
        step(4);
        check({name, "_valid"}, 32'(sample_valid), 32'd1);
        check({name, "_left"}, 32'(lsound_out), 32'(el));
        check({name, "_right"}, 32'(rsound_out), 32'(er));
        lrck = 1'b0;
        step(1);
        check({name, "_valid_drop"}, 32'(sample_valid), 32'd0);
        step(2);
    endtask

    initial begin
        reg_vec_t    vecs[12];
        logic [31:0] rd;
        logic [47:0] pair;

        // Reset values
        step(2);
        check("rst_dataout", dataout, 32'h0);
        check("rst_lsound", 32'(lsound_out), 32'h0);
        check("rst_rsound", 32'(rsound_out), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_flags", {28'h0, sample_valid, refill_req, underrun, overflow}, 32'h0);
        reset_n = 1'b1;
        step(1);

        // Basic pair through one frame, with latency checks
        write_reg(ADDR_CTRL, 32'h1);
        push_pair(24'h123456, 24'hABCDEF);
        check("basic_level_push", 32'(fifo_level), 32'd1);
        lrck = 1'b1;
        step(3);
        check("basic_level_pop", 32'(fifo_level), 32'd0);
        check("basic_valid_early", 32'(sample_valid), 32'd0);
        step(1);
        check("basic_valid", 32'(sample_valid), 32'd1);
        check("basic_left", 32'(lsound_out), 32'h123456);
        check("basic_right", 32'(rsound_out), 32'hABCDEF);
        lrck = 1'b0;
        step(1);
        check("basic_valid_drop", 32'(sample_valid), 32'd0);
        step(2);

        // Register access table
        vecs[0]  = '{1'b0, ADDR_RIGHT,  32'h0,        32'hABCDEF00};
        vecs[1]  = '{1'b0, ADDR_LEFT,   32'h0,        32'h12345600};
        vecs[2]  = '{1'b1, ADDR_LEFT,   32'h112233FF, 32'h0};
        vecs[3]  = '{1'b0, ADDR_LEFT,   32'h0,        32'h11223300};
        vecs[4]  = '{1'b0, ADDR_CTRL,   32'h0,        32'h00000001};
        vecs[5]  = '{1'b0, ADDR_THRESH, 32'h0,        32'h00000000};
        vecs[6]  = '{1'b1, ADDR_RIGHT,  32'h00000000, 32'h0};
        vecs[7]  = '{1'b0, ADDR_THRESH, 32'h0,        32'h00000001};
        vecs[8]  = '{1'b1, ADDR_CTRL,   32'h00000005, 32'h0};
        vecs[9]  = '{1'b0, ADDR_THRESH, 32'h0,        32'h00000000};
        vecs[10] = '{1'b0, ADDR_LEFT,   32'h0,        32'h11223300};
        vecs[11] = '{1'b1, ADDR_CTRL,   32'h00000000, 32'h0};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                write_reg(vecs[i].addr, vecs[i].data);
            end else begin
                read_reg(vecs[i].addr, rd);
                check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
            end
        end
        read_reg(ADDR_CTRL, rd);
        check("reg_ctrl_off", rd, 32'h0);

        // Fill 65 pairs while disabled: the 65th is dropped
        for (int i = 0; i < 65; i++) begin
            pair = {24'h100000 + 24'(i), 24'h200000 + 24'(i * 3)};
            push_pair(pair[47:24], pair[23:0]);
            if (i < 64) exp_q.push_back(pair);
        end
        check("ovf_level", 32'(fifo_level), 32'd64);
        check("ovf_flag", 32'(overflow), 32'd1);
        read_reg(ADDR_CTRL, rd);
        check("ovf_status", rd, 32'h4);
        write_reg(ADDR_CTRL, 32'h3);
        check("ovf_clear", 32'(overflow), 32'd0);

        // Push coinciding with a frame tick at full level
        write_reg(ADDR_LEFT, 32'h5A5A5A00);
        lrck = 1'b1;
        step(2);
        write_reg(ADDR_RIGHT, 32'hA5A5A500);
        check("coin_level", 32'(fifo_level), 32'd64);
        check("coin_no_ovf", 32'(overflow), 32'd0);
        step(1);
        pair = exp_q.pop_front();
        check("coin_left", 32'(lsound_out), 32'(pair[47:24]));
        check("coin_right", 32'(rsound_out), 32'(pair[23:0]));
        exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
        lrck = 1'b0;
        step(3);

        // Drain: pairs must come out in write order
        for (int i = 0; i < 64; i++) begin
            pair = exp_q.pop_front();
            frame_check(pair[47:24], pair[23:0], $sformatf("drain%0d", i));
        end
        check("drain_level", 32'(fifo_level), 32'd0);
        read_reg(ADDR_CTRL, rd);
        check("drain_status", rd, 32'h1);

        // Underrun on an empty FIFO, then clear
        frame_check(24'h0, 24'h0, "undr");
        check("undr_flag", 32'(underrun), 32'd1);
        read_reg(ADDR_CTRL, rd);
        check("undr_status", rd, 32'h3);
        write_reg(ADDR_CTRL, 32'h3);
        check("undr_clear", 32'(underrun), 32'd0);

        // Disabled frame: silence, no pop, no flag
        push_pair(24'h111111, 24'h222222);
        push_pair(24'h333333, 24'h444444);
        frame_check(24'h111111, 24'h222222, "en_pop");
        write_reg(ADDR_CTRL, 32'h0);
        frame_check(24'h0, 24'h0, "dis");
        check("dis_level", 32'(fifo_level), 32'd1);
        check("dis_undr", 32'(underrun), 32'd0);

        // Refill threshold
        write_reg(ADDR_CTRL, 32'h5);
        check("thr_flush_level", 32'(fifo_level), 32'd0);
        write_reg(ADDR_THRESH, 32'd4);
        check("thr_refill_empty", 32'(refill_req), 32'd1);
        for (int i = 0; i < 3; i++) push_pair(24'h0A0000 + 24'(i), 24'h0B0000 + 24'(i));
        check("thr_refill_3", 32'(refill_req), 32'd1);
        push_pair(24'h0A0003, 24'h0B0003);
        check("thr_refill_4", 32'(refill_req), 32'd0);
        check("thr_level_4", 32'(fifo_level), 32'd4);

        // Flush with 10 queued, coinciding with a frame tick
        for (int i = 0; i < 6; i++) push_pair(24'h0C0000 + 24'(i), 24'h0D0000 + 24'(i));
        check("flush_level_10", 32'(fifo_level), 32'd10);
        lrck = 1'b1;
        step(2);
        write_reg(ADDR_CTRL, 32'h5);
        check("flush_level_0", 32'(fifo_level), 32'd0);
        check("flush_refill", 32'(refill_req), 32'd1);
        lrck = 1'b0;
        step(3);
        read_reg(ADDR_LEFT, rd);
        check("flush_left_hold", rd, 32'h0C000500);

        // Asynchronous reset mid-stream
        push_pair(24'h777777, 24'h888888);
        push_pair(24'h999999, 24'h666666);
        frame_check(24'h777777, 24'h888888, "pre_rst");
        read_reg(ADDR_RIGHT, rd);
        check("pre_rst_read", rd, 32'h88888800);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_lsound", 32'(lsound_out), 32'h0);
        check("arst_rsound", 32'(rsound_out), 32'h0);
        check("arst_dataout", dataout, 32'h0);
        check("arst_level", 32'(fifo_level), 32'h0);
        check("arst_refill", 32'(refill_req), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1);
        read_reg(ADDR_CTRL, rd);
        check("arst_status", rd, 32'h0);
        frame_check(24'h0, 24'h0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
